// File: rtl/regbank_pkg.sv
// Shared types and defaults for the register-bank write-back arbiter.
// Optional feature macro: REGBANK_X0_HARDWIRE_EN (address 0 hardwired constant).
package regbank_pkg;

  localparam int RB_ADDR_WIDTH = 6;
  localparam int RB_DATA_WIDTH = 32;
  localparam int RB_NUM_REGS   = 64;

  // Side that received the most recent grant.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } last_e;

  // One write-back request as seen by the arbiter.
  typedef struct packed {
    logic                     valid;
    logic [RB_ADDR_WIDTH-1:0] addr;
    logic [RB_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regbank_scoreboard.sv
// Load scoreboard: busy bit per register, running busy count, RAW hazard flag.
// Optional feature macro: REGBANK_X0_HARDWIRE_EN (register 0 never busy/hazardous).
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
  parameter int NUM_REGS   = RB_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_issue_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [ADDR_WIDTH-1:0] src_a_i,
  input  logic [ADDR_WIDTH-1:0] src_b_i,
  output logic                  hazard_o,
  output logic [ADDR_WIDTH:0]   pend_cnt_o
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                set, inc, dec;

  // Next busy vector and incremental count; a set beats a clear on the same register.
  always_comb begin
`ifdef REGBANK_X0_HARDWIRE_EN
    set = ld_issue_i & (|ld_addr_i);
`else
    set = ld_issue_i;
`endif
    inc    = set & ~busy_q[ld_addr_i];
    dec    = clr_i & busy_q[clr_addr_i] & ~(set & (ld_addr_i == clr_addr_i));
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set)   busy_d[ld_addr_i]  = 1'b1;
    cnt_d  = cnt_q + CW'(inc) - CW'(dec);
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Hazard looks only at registered state, so a clear this cycle is not bypassed.
  always_comb begin
`ifdef REGBANK_X0_HARDWIRE_EN
    hazard_o = (busy_q[src_a_i] & (|src_a_i)) | (busy_q[src_b_i] & (|src_b_i));
`else
    hazard_o = busy_q[src_a_i] | busy_q[src_b_i];
`endif
  end

  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Round-robin ALU/MEM write-back arbiter with a registered register-bank write port.
// Same-address collisions grant MEM first so the younger ALU value lands last.
// Optional feature macro: REGBANK_X0_HARDWIRE_EN (address 0 hardwired constant).
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
  parameter int DATA_WIDTH = RB_DATA_WIDTH,
  parameter int NUM_REGS   = RB_NUM_REGS
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ALU_VALID,
  input  logic [ADDR_WIDTH-1:0] ALU_ADDR,
  input  logic [DATA_WIDTH-1:0] ALU_DATA,
  output logic                  ALU_READY,
  input  logic                  MEM_VALID,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0] MEM_DATA,
  output logic                  MEM_READY,
  input  logic                  LD_ISSUE,
  input  logic [ADDR_WIDTH-1:0] LD_ADDR,
  input  logic [ADDR_WIDTH-1:0] SRC_A,
  input  logic [ADDR_WIDTH-1:0] SRC_B,
  output logic                  HAZARD,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic [ADDR_WIDTH:0]   PEND_CNT
);

  wb_req_t alu_req, mem_req, win_req;
  last_e   last_q, last_d;
  logic    coll, alu_gnt, mem_gnt, xfer, wr_en_d;
  logic    wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  assign alu_req = '{valid: ALU_VALID, addr: ALU_ADDR, data: ALU_DATA};
  assign mem_req = '{valid: MEM_VALID, addr: MEM_ADDR, data: MEM_DATA};

  // Grant selection: lone requester wins, collisions favour MEM, otherwise alternate.
  always_comb begin
    coll = alu_req.valid & mem_req.valid & (alu_req.addr == mem_req.addr);
`ifdef REGBANK_X0_HARDWIRE_EN
    coll = coll & (|mem_req.addr);
`endif
    mem_gnt = mem_req.valid & (~alu_req.valid | coll | (last_q == GNT_ALU));
    alu_gnt = alu_req.valid & ~mem_gnt;
    xfer    = alu_gnt | mem_gnt;
    win_req = mem_gnt ? mem_req : alu_req;
    wr_en_d = xfer;
`ifdef REGBANK_X0_HARDWIRE_EN
    wr_en_d = xfer & (|win_req.addr);
`endif
    last_d = last_q;
    if (mem_gnt)      last_d = GNT_MEM;
    else if (alu_gnt) last_d = GNT_ALU;
  end

  // Arbiter state and one-cycle write pipeline; reset drops any pending write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q    <= GNT_ALU;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      last_q  <= last_d;
      wr_en_q <= wr_en_d;
      if (xfer) begin
        wr_addr_q <= win_req.addr;
        wr_data_q <= win_req.data;
      end
    end
  end

  assign ALU_READY = alu_gnt;
  assign MEM_READY = mem_gnt;
  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;

  regbank_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_sb (
    .clk        (CLK),
    .rst_n      (RST_N),
    .ld_issue_i (LD_ISSUE),
    .ld_addr_i  (LD_ADDR),
    .clr_i      (mem_gnt),
    .clr_addr_i (MEM_ADDR),
    .src_a_i    (SRC_A),
    .src_b_i    (SRC_B),
    .hazard_o   (HAZARD),
    .pend_cnt_o (PEND_CNT)
  );

endmodule
